uart_rx: RTL and testbench
==========================

# uart_rx

Oversampling UART receiver that turns the serial line back into parallel frames. It is the receive-side counterpart of the UART transmitter: it accepts the same frame format (start bit, `FRAME_WIDTH` data bits LSB first, optional even/odd parity, one stop bit) and presents each good frame on a parallel bus with a one-cycle valid strobe. It uses a single `clk` domain that runs at `prescale` times the bit rate, and it also flags parity and stop-bit errors.

## Interface
- `FRAME_WIDTH`, default 8: number of data bits per frame.
- `clk`  in  1  oversampling clock, `prescale` cycles per bit.
- `reset`  in  1  asynchronous, active-low reset. One clock domain (`clk`) only.
- `RX_IN`  in  1  serial line; idles high. Already synchronised upstream.
- `prescale`  in  6  oversampling ratio. Values below 8 are treated as 8. The LSB is ignored, so odd values round down.
- `par_en`  in  1  parity bit present.
- `par_typ`  in  1  parity type: 0 = even, 1 = odd.
- `P_DATA`  out  `FRAME_WIDTH`  last good frame; holds its value until the next good frame.
- `data_valid`  out  1  one-cycle pulse when `P_DATA` updates.
- `par_err`  out  1  one-cycle pulse when the parity check fails.
- `stp_err`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **Registers:**
  - `edge_cnt`: 0..P-1 within each bit.
  - `bit_cnt`: data bit index.
  - shift register for incoming data.
  - 3-sample vote register.
  - `armed` flag.
- **Latching:** `prescale` (clamped, as P), `par_en` and `par_typ` are latched when a start is detected. Changes during a frame are ignored.
- **Majority vote:** with h = P/2, `RX_IN` is sampled at edges h-1, h and h+1. The majority value (vote) is registered at edge h+2.
- **IDLE:**
  - `armed` sets once `RX_IN` is seen high.
  - If `armed` and `RX_IN` = 0, go to START with `edge_cnt` = 1; that cycle counts as edge 0.
- **START:**
  - At edge h+2, vote = 1 is a false start: go to IDLE, clear `armed`, raise no flags.
  - Otherwise, at edge P-1 go to DATA with `bit_cnt` = 0.
- **DATA:**
  - At edge P-1, shift the vote in at bit `bit_cnt` (LSB first).
  - After bit `FRAME_WIDTH`-1, go to PARITY if `par_en`, else STOP.
- **PARITY:**
  - At edge P-1, compare the vote with the expected parity: XOR of the data bits, XOR `par_typ`.
  - Store the mismatch result internally, then go to STOP.
- **STOP:** at edge P-1, go to IDLE and register the frame result on the next cycle:
  - vote = 0: `stp_err` = 1.
  - Otherwise, if a parity mismatch was stored: `par_err` = 1.
  - Otherwise: `data_valid` = 1 and `P_DATA` is loaded from the shift register.
  - Exactly one of `data_valid`, `par_err`, `stp_err` pulses per completed frame; a stop error takes precedence over a parity error.
- **Errored frames:** `P_DATA` is not updated.
- **`armed` after a frame:** remains set on exit from STOP, so a start bit immediately after the stop bit is accepted. The receiver may lose at most one cycle of alignment per frame, which the centre sampling absorbs.

## Timing
- **Reset values:** `P_DATA` = 0, `data_valid` = 0, `par_err` = 0, `stp_err` = 0, state = IDLE, `armed` = 0, all counters = 0.
- **Latency:** with N = `FRAME_WIDTH` + 2 + `par_en` and t0 = the start-detect cycle, the result pulse occurs at t0 + N·P.
  - Example: 8N1 with P = 8 gives t0 + 80.
- **Pulse width:** all output pulses are exactly 1 cycle and fully registered; outputs have no combinational path from inputs.
- **Reset mid-frame:** the frame is aborted with no pulses. `armed` clears, so a line that is still low (mid-frame or a break) is not taken as a start until `RX_IN` returns high and then falls.
- **Break condition:** `RX_IN` held low produces `stp_err` once, then no further activity until the line returns high.

## Test plan
- **8N1, P = 8, byte 0xA5:** `data_valid` pulses once at t0+80, `P_DATA` = 0xA5, `par_err` = `stp_err` = 0.
- **Even parity, P = 16, 0x3C with parity bit 0:** valid at t0+176, `P_DATA` = 0x3C.
  - Repeat with parity bit 1: `par_err` pulses, no `data_valid`, `P_DATA` stays 0x3C.
- **Stop bit driven 0 (8N1, 0x55):** `stp_err` pulse at t0+80, no `data_valid`; `P_DATA` unchanged.
- **`RX_IN` low for 2 cycles at P = 8:** returns to IDLE, no pulses.
  - A following valid 0x81 frame is still received correctly.
- **Reset asserted mid-DATA with `RX_IN` held low, then released:** no start is detected until `RX_IN` goes high then low.
  - Next frame 0x7E is received correctly.
- **Back-to-back frames 0x00 then 0xFF, P = 8:** one sample per bit inverted at edge h-1; the majority vote recovers both.
  - Two `data_valid` pulses, 80 ±1 cycles apart.

Source files
------------

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start + FRAME_WIDTH data (LSB first) + optional parity + stop.
// Result pulse N*P cycles after start detect; no backpressure, every frame yields exactly one pulse.
module uart_rx #(
  parameter int FRAME_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   RX_IN,
  input  logic [5:0]             prescale,
  input  logic                   par_en,
  input  logic                   par_typ,
  output logic [FRAME_WIDTH-1:0] P_DATA,
  output logic                   data_valid,
  output logic                   par_err,
  output logic                   stp_err
);

  localparam int BW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]             state_q,      state_d;
  logic [5:0]             edge_cnt_q,   edge_cnt_d;
  logic [BW-1:0]          bit_cnt_q,    bit_cnt_d;
  logic [FRAME_WIDTH-1:0] shift_q,      shift_d;
  logic [2:0]             smp_q,        smp_d;
  logic                   vote_q,       vote_d;
  logic                   armed_q,      armed_d;
  logic [5:0]             p_q,          p_d;
  logic                   par_en_q,     par_en_d;
  logic                   par_typ_q,    par_typ_d;
  logic                   par_bad_q,    par_bad_d;
  logic [FRAME_WIDTH-1:0] p_data_q,     p_data_d;
  logic                   data_valid_q, data_valid_d;
  logic                   par_err_q,    par_err_d;
  logic                   stp_err_q,    stp_err_d;

  logic [5:0] p_in;
  logic [5:0] p_clamp;
  logic [5:0] half;
  logic       last_edge;
  logic       in_win;
  logic       vote_edge;
  logic       maj;
  logic       exp_par;

  always_comb begin
    p_in      = {prescale[5:1], 1'b0};
    p_clamp   = (p_in < 6'd8) ? 6'd8 : p_in;
    half      = {1'b0, p_q[5:1]};
    last_edge = (edge_cnt_q == (p_q - 6'd1));
    in_win    = (edge_cnt_q == (half - 6'd1)) || (edge_cnt_q == half) ||
                (edge_cnt_q == (half + 6'd1));
    vote_edge = (edge_cnt_q == (half + 6'd2));
    maj       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
    exp_par   = (^shift_q) ^ par_typ_q;
  end

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    smp_d        = smp_q;
    vote_d       = vote_q;
    armed_d      = armed_q;
    p_d          = p_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    if (state_q != S_IDLE) begin
      edge_cnt_d = last_edge ? 6'd0 : edge_cnt_q + 6'd1;
      if (in_win) begin
        smp_d = {smp_q[1:0], RX_IN};
      end
      if (vote_edge) begin
        vote_d = maj;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (RX_IN) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          // The detect cycle itself is edge 0 of the start bit.
          state_d    = S_START;
          edge_cnt_d = 6'd1;
          bit_cnt_d  = '0;
          p_d        = p_clamp;
          par_en_d   = par_en;
          par_typ_d  = par_typ;
          par_bad_d  = 1'b0;
        end
      end
      S_START: begin
        if (vote_edge && maj) begin
          state_d    = S_IDLE;
          edge_cnt_d = 6'd0;
          armed_d    = 1'b0;
        end else if (last_edge) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (last_edge) begin
          shift_d                = shift_q >> 1;
          shift_d[FRAME_WIDTH-1] = vote_q;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (last_edge) begin
          par_bad_d = (vote_q != exp_par);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (last_edge) begin
          state_d = S_IDLE;
          if (!vote_q) begin
            // Low stop bit: disarm so a held-low line (break) reports only once.
            stp_err_d = 1'b1;
            armed_d   = 1'b0;
          end else if (par_bad_q) begin
            par_err_d = 1'b1;
          end else begin
            data_valid_d = 1'b1;
            p_data_d     = shift_q;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        edge_cnt_d = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      smp_q        <= '0;
      vote_q       <= 1'b0;
      armed_q      <= 1'b0;
      p_q          <= 6'd8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      smp_q        <= smp_d;
      vote_q       <= vote_d;
      armed_q      <= armed_d;
      p_q          <= p_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

  a_one_result: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({data_valid_q, par_err_q, stp_err_q}));

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised here, expected results queued at start.
// Each result pulse is popped and checked for kind, P_DATA and arrival cycle.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] last_good = 8'h00;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  localparam int K_VALID = 1;
  localparam int K_PAR   = 2;
  localparam int K_STP   = 4;

  uart_rx #(.FRAME_WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .RX_IN      (RX_IN),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total = total + 1;
    if (obs != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (data_valid || par_err || stp_err) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pulse", {stp_err, par_err, data_valid}, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result_kind", {stp_err, par_err, data_valid}, e.kind);
        chk("p_data", P_DATA, e.data);
        chk("latency", cyc, e.cyc);
      end
    end
  end

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; p is the effective ratio the DUT should use.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe, input logic pt,
                            input logic flip_par, input logic stop_bit, input logic glitch);
    logic [11:0] fr;
    int          nb;
    exp_t        e;
    fr    = '0;
    fr[0] = 1'b0;
    for (int i = 0; i < 8; i++) fr[1+i] = d[i];
    nb = 9;
    if (pe) begin
      fr[nb] = (^d) ^ pt ^ flip_par;
      nb     = nb + 1;
    end
    fr[nb] = stop_bit;
    nb     = nb + 1;
    e.cyc  = cyc + nb * p;
    if (!stop_bit) begin
      e.kind = K_STP;
    end else if (pe && flip_par) begin
      e.kind = K_PAR;
    end else begin
      e.kind    = K_VALID;
      last_good = d;
    end
    e.data = last_good;
    sb_q.push_back(e);
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < p; j++) begin
        RX_IN = (glitch && j == p / 2 - 1) ? ~fr[b] : fr[b];
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    RX_IN    = 1'b1;
    prescale = 6'd8;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_p_data", P_DATA, 0);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_par_err", par_err, 0);
    chk("rst_stp_err", stp_err, 0);
    reset = 1'b1;
    idle(10);

    // 8N1, P=8
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);

    // Even parity, P=16: good parity then flipped parity
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(20);

    // Stop bit low
    prescale = 6'd8; par_en = 1'b0;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(20);

    // Two-cycle glitch: false start, then a real frame
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    idle(20);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);

    // Odd parity, odd prescale rounds down to 10
    prescale = 6'd11; par_en = 1'b1; par_typ = 1'b1;
    send_frame(8'h01, 10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(20);

    // Prescale below 8 is clamped to 8
    prescale = 6'd3; par_en = 1'b0; par_typ = 1'b0;
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);

    // Reset mid-DATA with line held low; no start until the line rises and falls
    prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (30) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    last_good = 8'h00;
    chk("midrst_p_data", P_DATA, 0);
    reset = 1'b1;
    repeat (120) @(negedge clk);
    idle(10);
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);

    // Back-to-back with one inverted sample per bit
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(20);

    // Break: one stop error, then silence while low
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (200) @(negedge clk);
    idle(30);

    chk("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
